// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for one shared single-ported memory
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    output logic        o_if_ready,
    output logic        o_if_valid,
    output logic [31:0] o_if_rdata,
    input  logic        i_d_req,
    input  logic        i_d_wen,
    input  logic [31:0] i_d_addr,
    input  logic [31:0] i_d_wdata,
    input  logic [3:0]  i_d_mask,
    output logic        o_d_ready,
    output logic        o_d_valid,
    output logic [31:0] o_d_rdata,
    output logic        o_mem_req,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_mask,
    input  logic        i_mem_ready,
    input  logic        i_mem_valid,
    input  logic [31:0] i_mem_rdata,
    output logic        o_busy
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t         state;
    state_t         state_nxt;
    logic           grant_if;
    logic [CW-1:0]  starve_cnt;
    logic           starve_hit;
    logic           pick_if;
    logic           unused_addr_bits;

    assign starve_hit = (starve_cnt == CW'(STARVE_LIMIT));
    // Data wins a tie unless fetch has been passed over STARVE_LIMIT times in a row.
    assign pick_if    = i_if_req && (!i_d_req || starve_hit);

    assign o_mem_req  = (state == REQ);
    assign o_busy     = (state != IDLE);
    assign o_if_ready = (state == REQ) && i_mem_ready && grant_if;
    assign o_d_ready  = (state == REQ) && i_mem_ready && !grant_if;

    assign unused_addr_bits = &{1'b0, i_if_addr[1:0], i_d_addr[1:0]};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (i_if_req || i_d_req) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (i_mem_ready) begin
                    state_nxt = o_mem_wen ? IDLE : WAIT;
                end
            end
            WAIT: begin
                if (i_mem_valid) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            grant_if    <= 1'b0;
            starve_cnt  <= '0;
            o_mem_wen   <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_mem_mask  <= '0;
            o_if_valid  <= 1'b0;
            o_d_valid   <= 1'b0;
            o_if_rdata  <= '0;
            o_d_rdata   <= '0;
        end else begin
            o_if_valid <= 1'b0;
            o_d_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_if_req || i_d_req) begin
                        grant_if <= pick_if;
                        if (pick_if) begin
                            o_mem_wen   <= 1'b0;
                            o_mem_addr  <= {i_if_addr[31:2], 2'b00};
                            o_mem_wdata <= '0;
                            o_mem_mask  <= 4'b1111;
                        end else begin
                            o_mem_wen   <= i_d_wen;
                            o_mem_addr  <= {i_d_addr[31:2], 2'b00};
                            o_mem_wdata <= i_d_wdata;
                            o_mem_mask  <= i_d_mask;
                        end
                        // Only a data grant that bypasses a waiting fetch counts toward starvation.
                        if (!pick_if && i_if_req) begin
                            if (!starve_hit) begin
                                starve_cnt <= starve_cnt + CW'(1);
                            end
                        end else begin
                            starve_cnt <= '0;
                        end
                    end
                end
                REQ: begin
                    if (i_mem_ready && o_mem_wen) begin
                        o_d_valid <= 1'b1;
                    end
                end
                WAIT: begin
                    if (i_mem_valid) begin
                        if (grant_if) begin
                            o_if_valid <= 1'b1;
                            o_if_rdata <= i_mem_rdata;
                        end else begin
                            o_d_valid  <= 1'b1;
                            o_d_rdata  <= i_mem_rdata;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_if_req, i_d_req, i_d_wen;
    logic [31:0] i_if_addr, i_d_addr, i_d_wdata;
    logic [3:0]  i_d_mask;
    logic        o_if_ready, o_if_valid, o_d_ready, o_d_valid;
    logic [31:0] o_if_rdata, o_d_rdata;
    logic        o_mem_req, o_mem_wen, o_busy;
    logic [31:0] o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_mask;
    logic        i_mem_ready, i_mem_valid;
    logic [31:0] i_mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_if_req(i_if_req), .i_if_addr(i_if_addr),
        .o_if_ready(o_if_ready), .o_if_valid(o_if_valid), .o_if_rdata(o_if_rdata),
        .i_d_req(i_d_req), .i_d_wen(i_d_wen), .i_d_addr(i_d_addr),
        .i_d_wdata(i_d_wdata), .i_d_mask(i_d_mask),
        .o_d_ready(o_d_ready), .o_d_valid(o_d_valid), .o_d_rdata(o_d_rdata),
        .o_mem_req(o_mem_req), .o_mem_wen(o_mem_wen), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_mem_mask(o_mem_mask),
        .i_mem_ready(i_mem_ready), .i_mem_valid(i_mem_valid), .i_mem_rdata(i_mem_rdata),
        .o_busy(o_busy)
    );

    typedef struct {bit is_if; bit is_wr; logic [31:0] data;} resp_t;
    typedef struct {bit is_if; logic [31:0] addr; bit wen; logic [31:0] wdata; logic [3:0] mask;} gnt_t;

    resp_t       resp_q[$];
    gnt_t        gnt_q[$];
    bit          gnt_log[$];
    logic [31:0] ref_mem[256];
    logic [31:0] dmem[256];
    int          n_chk = 0;
    int          n_fail = 0;
    int          mem_mode = 1;

    function automatic logic [31:0] init_word(int i);
        if (i == 64) return 32'h0000_0013;
        return 32'hA500_0000 ^ (i * 32'h0001_0203);
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Downstream memory: mode 0 random, 1 zero-wait, 2 ready after 3 stall cycles,
    // 3 zero-wait plus a stray valid every idle cycle, 4 accepts but never answers.
    initial begin
        int          wait_cnt;
        bit          pend;
        logic [31:0] pend_data;
        for (int i = 0; i < 256; i++) dmem[i] = init_word(i);
        i_mem_ready = 1'b0; i_mem_valid = 1'b0; i_mem_rdata = '0;
        pend = 1'b0; wait_cnt = 0; pend_data = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend = 1'b0;
            end else if (o_mem_req && i_mem_ready) begin
                if (o_mem_wen) begin
                    dmem[o_mem_addr[9:2]] = merge(dmem[o_mem_addr[9:2]], o_mem_wdata, o_mem_mask);
                end else begin
                    pend = 1'b1;
                    pend_data = dmem[o_mem_addr[9:2]];
                end
            end
            @(posedge clk); #1;
            if (mem_mode == 0) begin
                i_mem_ready = ($urandom_range(0, 2) != 0);
            end else if (mem_mode == 2) begin
                if (o_mem_req) begin
                    i_mem_ready = (wait_cnt == 3);
                    wait_cnt++;
                end else begin
                    i_mem_ready = 1'b0;
                    wait_cnt = 0;
                end
            end else begin
                i_mem_ready = 1'b1;
            end
            if (pend && mem_mode != 4 && (mem_mode != 0 || $urandom_range(0, 1) == 1)) begin
                i_mem_valid = 1'b1; i_mem_rdata = pend_data; pend = 1'b0;
            end else if (!pend && (mem_mode == 3 || (mem_mode == 0 && $urandom_range(0, 7) == 0))) begin
                i_mem_valid = 1'b1; i_mem_rdata = $urandom;
            end else begin
                i_mem_valid = 1'b0;
            end
        end
    end

    // Requester side: expected response is fixed when a request is accepted.
    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (o_if_ready) resp_q.push_back('{1'b1, 1'b0, ref_mem[i_if_addr[9:2]]});
                if (o_d_ready) begin
                    if (i_d_wen) begin
                        ref_mem[i_d_addr[9:2]] = merge(ref_mem[i_d_addr[9:2]], i_d_wdata, i_d_mask);
                        resp_q.push_back('{1'b0, 1'b1, 32'h0});
                    end else begin
                        resp_q.push_back('{1'b0, 1'b0, ref_mem[i_d_addr[9:2]]});
                    end
                end
            end
        end
    end

    // Monitor: arbitration model plus response scoreboard.
    initial begin
        bit    busy_m;
        int    cnt_m;
        bit    f_win;
        gnt_t  g;
        resp_t r;
        busy_m = 1'b0; cnt_m = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_m = 1'b0; cnt_m = 0;
                gnt_q.delete(); resp_q.delete();
            end else begin
                if (o_if_valid || o_d_valid) begin
                    check("valid_exclusive", {31'b0, o_if_valid && o_d_valid}, 0);
                    if (resp_q.size() == 0) begin
                        check("resp_unexpected", 1, 0);
                    end else begin
                        r = resp_q.pop_front();
                        check("resp_port", {31'b0, o_if_valid}, {31'b0, r.is_if});
                        if (!r.is_wr) check("resp_rdata", r.is_if ? o_if_rdata : o_d_rdata, r.data);
                    end
                    busy_m = 1'b0;
                end
                if (!busy_m) begin
                    check("idle_mem_req", {31'b0, o_mem_req}, 0);
                    check("idle_busy", {31'b0, o_busy}, 0);
                    if (i_if_req || i_d_req) begin
                        f_win = i_if_req && (!i_d_req || cnt_m == LIMIT);
                        if (f_win) begin
                            g = '{1'b1, {i_if_addr[31:2], 2'b00}, 1'b0, 32'h0, 4'hF};
                            cnt_m = 0;
                        end else begin
                            g = '{1'b0, {i_d_addr[31:2], 2'b00}, i_d_wen, i_d_wdata, i_d_mask};
                            cnt_m = i_if_req ? ((cnt_m < LIMIT) ? cnt_m + 1 : cnt_m) : 0;
                        end
                        gnt_q.push_back(g);
                        busy_m = 1'b1;
                    end
                end
                if (o_if_ready || o_d_ready) begin
                    check("ready_exclusive", {31'b0, o_if_ready && o_d_ready}, 0);
                    gnt_log.push_back(o_if_ready);
                    if (gnt_q.size() == 0) begin
                        check("grant_unexpected", 1, 0);
                    end else begin
                        g = gnt_q.pop_front();
                        check("grant_port", {31'b0, o_if_ready}, {31'b0, g.is_if});
                        check("grant_addr", o_mem_addr, g.addr);
                        check("grant_wen", {31'b0, o_mem_wen}, {31'b0, g.wen});
                        check("grant_mask", {28'b0, o_mem_mask}, {28'b0, g.mask});
                        if (g.wen) check("grant_wdata", o_mem_wdata, g.wdata);
                    end
                end
            end
        end
    end

    task automatic drive_cycles(int n, int p_if, int p_d);
        bit a_if, a_d;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            a_if = o_if_ready; a_d = o_d_ready;
            @(posedge clk); #1;
            if (a_if) i_if_req = 1'b0;
            if (a_d) i_d_req = 1'b0;
            if (!i_if_req && $urandom_range(0, 99) < p_if) begin
                i_if_req = 1'b1; i_if_addr = $urandom;
            end
            if (!i_d_req && $urandom_range(0, 99) < p_d) begin
                i_d_req = 1'b1; i_d_wen = $urandom_range(0, 1);
                i_d_addr = $urandom; i_d_wdata = $urandom; i_d_mask = 4'($urandom_range(1, 15));
            end
        end
    endtask

    task automatic drain();
        for (int c = 0; c < 600 && (i_if_req || i_d_req || resp_q.size() != 0); c++) drive_cycles(1, 0, 0);
        check("drain_done", {31'b0, i_if_req || i_d_req || resp_q.size() != 0}, 0);
    endtask

    // Single request; cycle 0 is the first cycle the request is visible.
    task automatic run_one(bit is_if, bit wen, logic [31:0] addr, logic [31:0] wdata, logic [3:0] mask,
                           output int t_rdy, output int t_val);
        @(posedge clk); #1;
        if (is_if) begin
            i_if_req = 1'b1; i_if_addr = addr;
        end else begin
            i_d_req = 1'b1; i_d_wen = wen; i_d_addr = addr; i_d_wdata = wdata; i_d_mask = mask;
        end
        t_rdy = -1; t_val = -1;
        for (int c = 0; c < 60 && t_val < 0; c++) begin
            @(negedge clk);
            if (o_mem_req) check("req_addr_stable", o_mem_addr, {addr[31:2], 2'b00});
            if (t_rdy < 0 && (is_if ? o_if_ready : o_d_ready)) t_rdy = c;
            if (is_if ? o_if_valid : o_d_valid) t_val = c;
            @(posedge clk); #1;
            if (t_rdy >= 0) begin i_if_req = 1'b0; i_d_req = 1'b0; end
        end
        check("run_one_timeout", {31'b0, t_val < 0}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        int          tr, tv;
        logic [31:0] w0, save_if, save_d;
        bit          got;
        rst_n = 1'b0;
        i_if_req = 0; i_if_addr = 0; i_d_req = 0; i_d_wen = 0; i_d_addr = 0; i_d_wdata = 0; i_d_mask = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outputs_zero", {31'b0, |{o_if_ready, o_if_valid, o_if_rdata, o_d_ready, o_d_valid, o_d_rdata,
              o_mem_req, o_mem_wen, o_mem_addr, o_mem_wdata, o_mem_mask, o_busy}}, 0);
        check("rst_busy", {31'b0, o_busy}, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        mem_mode = 1;
        run_one(1'b1, 1'b0, 32'h100, 32'h0, 4'hF, tr, tv);
        check("fetch_ready_cycle", tr, 1);
        check("fetch_valid_cycle", tv, 3);
        check("fetch_rdata", o_if_rdata, 32'h13);

        mem_mode = 2;
        run_one(1'b0, 1'b1, 32'h2003, 32'hDEAD_BEEF, 4'b1000, tr, tv);
        check("store_stall_ready_cycle", tr, 4);
        check("store_valid_after_ready", tv, tr + 1);

        mem_mode = 1;
        run_one(1'b0, 1'b0, 32'h2000, 32'h0, 4'hF, tr, tv);
        w0 = init_word(0);
        check("load_back_rdata", o_d_rdata, {8'hDE, w0[23:0]});
        check("load_valid_cycle", tv, 3);

        mem_mode = 3;
        save_if = o_if_rdata; save_d = o_d_rdata;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("stray_no_valid", {31'b0, o_if_valid || o_d_valid}, 0);
        end
        check("stray_if_rdata_held", o_if_rdata, save_if);
        check("stray_d_rdata_held", o_d_rdata, save_d);

        mem_mode = 4;
        @(posedge clk); #1 i_if_req = 1'b1; i_if_addr = 32'h40;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            got = o_if_ready;
        end
        check("wait_fetch_accepted", {31'b0, got}, 1);
        @(posedge clk); #1 i_if_req = 1'b0;
        @(negedge clk);
        check("in_wait_busy", {31'b0, o_busy}, 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_outputs_zero", {31'b0, |{o_if_ready, o_if_valid, o_if_rdata, o_d_ready, o_d_valid, o_d_rdata,
              o_mem_req, o_mem_wen, o_mem_addr, o_mem_wdata, o_mem_mask, o_busy}}, 0);
        mem_mode = 3;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("post_rst_no_valid", {31'b0, o_if_valid || o_d_valid}, 0);
        end

        mem_mode = 1;
        gnt_log.delete();
        @(posedge clk); #1;
        i_if_req = 1'b1; i_if_addr = 32'h0;
        i_d_req = 1'b1; i_d_wen = 1'b0; i_d_addr = 32'h8; i_d_mask = 4'hF;
        drain();
        check("tie_grant_count", gnt_log.size(), 2);
        if (gnt_log.size() == 2) begin
            check("tie_first_is_data", {31'b0, gnt_log[0]}, 0);
            check("tie_second_is_fetch", {31'b0, gnt_log[1]}, 1);
        end

        gnt_log.delete();
        for (int c = 0; c < 400 && gnt_log.size() < 10; c++) drive_cycles(1, 100, 100);
        drain();
        check("starve_grant_count", {31'b0, gnt_log.size() >= 10}, 1);
        for (int k = 0; k < 10 && k < gnt_log.size(); k++)
            check("starve_sequence", {31'b0, gnt_log[k]}, {31'b0, (k % 5) == 4});

        mem_mode = 0;
        drive_cycles(3000, 40, 40);
        drain();
        repeat (4) @(negedge clk);
        check("final_resp_q_empty", resp_q.size(), 0);
        check("final_gnt_q_empty", gnt_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
